// File: rtl/alu_vote_ctrl.sv
// alu_vote_ctrl
//   Sequencer and voter for a triplicated ALU. Accepts one operation over a
//   valid/ready request port, broadcasts registered operands to three ALU
//   replicas, captures their results, and votes on the 33-bit word
//   {zero, result}. It retries on total disagreement and returns the bitwise
//   2-of-3 majority over a valid/ready response port. It also keeps sticky
//   per-replica fault statistics.
//
// Ports
//   clk, reset                   clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_a, req_b, req_alucont    operands and ALU control code
//   alu_a, alu_b, alu_cont       registered operands to all replicas
//   alu_result_0..2, alu_zero_0..2  replica outputs
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_zero         majority result and zero flag
//   rsp_fault, rsp_fail          single replica masked / no agreement
//   stat_clr                     synchronous clear of the statistics
//   fault_mask, fault_count      sticky odd-replica mask, saturating count
module alu_vote_ctrl #(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [2:0]       req_alucont,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_cont,
    input  logic [31:0]      alu_result_0,
    input  logic [31:0]      alu_result_1,
    input  logic [31:0]      alu_result_2,
    input  logic             alu_zero_0,
    input  logic             alu_zero_1,
    input  logic             alu_zero_2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_fault,
    output logic             rsp_fail,
    input  logic             stat_clr,
    output logic [2:0]       fault_mask,
    output logic [CNT_W-1:0] fault_count
);

    typedef enum logic [1:0] {IDLE, EXEC, VOTE, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  retry;
    logic [32:0] word_0_p1;
    logic [32:0] word_1_p1;
    logic [32:0] word_2_p1;

    function automatic logic [32:0] majority(input logic [32:0] x, input logic [32:0] y,
                                             input logic [32:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic        eq01;
    logic        eq02;
    logic        eq12;
    logic        all_eq;
    logic        none_eq;
    logic        two_eq;
    logic [2:0]  odd_mask;
    logic        retry_left;
    logic [32:0] maj_word;

    assign eq01       = (word_0_p1 == word_1_p1);
    assign eq02       = (word_0_p1 == word_2_p1);
    assign eq12       = (word_1_p1 == word_2_p1);
    assign all_eq     = eq01 & eq12;
    assign none_eq    = ~(eq01 | eq02 | eq12);
    assign two_eq     = ~all_eq & ~none_eq;
    // With exactly one equal pair, the replica outside that pair is the odd one.
    assign odd_mask   = eq01 ? 3'b100 : (eq02 ? 3'b010 : 3'b001);
    assign retry_left = (retry < 3'(MAX_RETRY));
    assign maj_word   = majority(word_0_p1, word_1_p1, word_2_p1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = EXEC;
            EXEC: state_nxt = VOTE;
            VOTE: state_nxt = (none_eq && retry_left) ? EXEC : RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by reset so it reads low while reset is held.
    always_comb begin
        req_ready = (state == IDLE) && reset;
        rsp_valid = (state == RESP);
    end

    // Stage p0: operand issue and retry bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_cont <= '0;
            retry    <= '0;
        end else if (state == IDLE && req_valid) begin
            alu_a    <= req_a;
            alu_b    <= req_b;
            alu_cont <= req_alucont;
            retry    <= '0;
        end else if (state == VOTE && state_nxt == EXEC) begin
            retry    <= retry + 3'd1;
        end
    end

    // Stage p1: capture the replica words at the end of EXEC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_0_p1 <= '0;
            word_1_p1 <= '0;
            word_2_p1 <= '0;
        end else if (state == EXEC) begin
            word_0_p1 <= {alu_zero_0, alu_result_0};
            word_1_p1 <= {alu_zero_1, alu_result_1};
            word_2_p1 <= {alu_zero_2, alu_result_2};
        end
    end

    // Stage p2: response registers, loaded only on VOTE -> RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_fault  <= 1'b0;
            rsp_fail   <= 1'b0;
        end else if (state == VOTE && state_nxt == RESP) begin
            rsp_result <= maj_word[31:0];
            rsp_zero   <= maj_word[32];
            rsp_fault  <= two_eq;
            rsp_fail   <= none_eq;
        end
    end

    // Statistics: every non-unanimous vote counts; a clear on the same edge wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_mask  <= '0;
            fault_count <= '0;
        end else if (stat_clr) begin
            fault_mask  <= '0;
            fault_count <= '0;
        end else if (state == VOTE && !all_eq) begin
            fault_count <= sat_inc(fault_count);
            if (two_eq) fault_mask <= fault_mask | odd_mask;
        end
    end

endmodule

// File: tb/tb_alu_vote_ctrl.sv
module tb_alu_vote_ctrl;

    localparam int MAXR  = 2;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_a = '0, req_b = '0;
    logic [2:0]    req_alucont = '0;
    logic [31:0]   alu_a, alu_b;
    logic [2:0]    alu_cont;
    logic [31:0]   alu_result_0, alu_result_1, alu_result_2;
    logic          alu_zero_0, alu_zero_1, alu_zero_2;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_result;
    logic          rsp_zero, rsp_fault, rsp_fail;
    logic          stat_clr = 1'b0;
    logic [2:0]    fault_mask;
    logic [CW-1:0] fault_count;

    int total = 0;
    int bad   = 0;

    // replica override plan per execution, and the one currently applied
    bit          plan_en  [0:MAXR][0:2];
    logic [31:0] plan_val [0:MAXR][0:2];
    bit          cur_en   [0:2];
    logic [31:0] cur_val  [0:2];

    // reference model statistics
    int       m_cnt  = 0;
    bit [2:0] m_mask = '0;

    always #5 clk = ~clk;

    alu_vote_ctrl #(.MAX_RETRY(MAXR), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_alucont(req_alucont),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
        .alu_result_0(alu_result_0), .alu_result_1(alu_result_1), .alu_result_2(alu_result_2),
        .alu_zero_0(alu_zero_0), .alu_zero_1(alu_zero_1), .alu_zero_2(alu_zero_2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_fault(rsp_fault), .rsp_fail(rsp_fail),
        .stat_clr(stat_clr), .fault_mask(fault_mask), .fault_count(fault_count)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
        case (c)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    // behavioural replicas: golden ALU unless an override is applied
    assign alu_result_0 = cur_en[0] ? cur_val[0] : alu_ref(alu_a, alu_b, alu_cont);
    assign alu_result_1 = cur_en[1] ? cur_val[1] : alu_ref(alu_a, alu_b, alu_cont);
    assign alu_result_2 = cur_en[2] ? cur_val[2] : alu_ref(alu_a, alu_b, alu_cont);
    assign alu_zero_0   = (alu_result_0 == 32'd0);
    assign alu_zero_1   = (alu_result_1 == 32'd0);
    assign alu_zero_2   = (alu_result_2 == 32'd0);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] vote33(input logic [32:0] x, input logic [32:0] y,
                                           input logic [32:0] z);
        logic [32:0] r;
        for (int bi = 0; bi < 33; bi++) begin
            int ones;
            ones  = int'(x[bi]) + int'(y[bi]) + int'(z[bi]);
            r[bi] = (ones >= 2);
        end
        return r;
    endfunction

    task automatic clear_plan();
        for (int j = 0; j <= MAXR; j++)
            for (int i = 0; i < 3; i++) begin
                plan_en[j][i]  = 1'b0;
                plan_val[j][i] = '0;
            end
        for (int i = 0; i < 3; i++) begin
            cur_en[i]  = 1'b0;
            cur_val[i] = '0;
        end
    endtask

    task automatic apply_plan(input int j);
        for (int i = 0; i < 3; i++) begin
            cur_en[i]  = plan_en[j][i];
            cur_val[i] = plan_val[j][i];
        end
    endtask

    // Present a request and return at the negedge after the handshake edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        int w;
        @(negedge clk);
        req_a = a; req_b = b; req_alucont = c; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("req_ready_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                          input int hold, input bit clr);
        logic [31:0] g, r;
        logic [32:0] w [0:2];
        logic [32:0] mw;
        int          nexec, kind, lat, k;
        logic [37:0] frozen;

        // reference outcome from the vote rules
        g = alu_ref(a, b, c);
        nexec = 0; kind = 0;
        for (int j = 0; j <= MAXR; j++) begin
            for (int i = 0; i < 3; i++) begin
                r    = plan_en[j][i] ? plan_val[j][i] : g;
                w[i] = {(r == 32'd0), r};
            end
            nexec = j + 1;
            if (w[0] == w[1] && w[1] == w[2]) begin
                kind = 0;
                break;
            end else if (w[0] == w[1] || w[0] == w[2] || w[1] == w[2]) begin
                kind = 1;
                m_mask |= (w[0] == w[1]) ? 3'b100 : ((w[0] == w[2]) ? 3'b010 : 3'b001);
                if (m_cnt < CMAX) m_cnt++;
                break;
            end else begin
                if (m_cnt < CMAX) m_cnt++;
                if (j == MAXR) begin
                    kind = 2;
                    break;
                end
            end
        end
        if (clr) begin
            m_mask = '0;
            m_cnt  = 0;
        end
        mw  = vote33(w[0], w[1], w[2]);
        lat = 3 + 2 * (nexec - 1);

        stat_clr = clr;
        issue(a, b, c);
        check("busy_req_ready", 64'(req_ready), 64'd0);
        check("operands", {29'd0, alu_cont, alu_a}, {29'd0, c, a});

        for (k = 0; k < 30; k++) begin
            if (k % 2 == 0 && k / 2 <= MAXR) apply_plan(k / 2);
            if (rsp_valid) break;
            @(negedge clk);
        end
        check("latency", 64'(k + 1), 64'(lat));
        check("rsp_result", 64'(rsp_result), 64'(mw[31:0]));
        check("rsp_flags", {61'd0, rsp_zero, rsp_fault, rsp_fail},
              {61'd0, mw[32], (kind == 1), (kind == 2)});

        frozen = {rsp_valid, req_ready, rsp_fault, rsp_fail, rsp_zero, alu_cont[0], rsp_result};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("backpressure_frozen",
                  64'({rsp_valid, req_ready, rsp_fault, rsp_fail, rsp_zero, alu_cont[0], rsp_result}),
                  64'(frozen));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("after_accept", {62'd0, rsp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
        check("fault_mask", 64'(fault_mask), 64'(m_mask));
        check("fault_count", 64'(fault_count), 64'(m_cnt));
        stat_clr = 1'b0;
        clear_plan();
    endtask

    initial begin
        logic [31:0] ra, rb, g;
        logic [2:0]  rc;
        int          scen, rep;

        clear_plan();
        #12;
        // reset state
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_alu", {29'd0, alu_cont, alu_a}, 64'd0);
        check("rst_stats", {59'd0, fault_mask, fault_count}, 64'd0);
        check("rst_rsp", {30'd0, rsp_zero, rsp_fault, rsp_result}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'd1);

        // clean add
        run_op(32'd5, 32'd7, 3'b010, 0, 1'b0);

        // single fault on replica 1
        plan_en[0][1] = 1'b1; plan_val[0][1] = 32'hDEADBEEF;
        run_op(32'd5, 32'd7, 3'b010, 0, 1'b0);

        // retry recovery: distinct words first, clean second
        plan_en[0][0] = 1'b1; plan_val[0][0] = 32'h10;
        plan_en[0][1] = 1'b1; plan_val[0][1] = 32'h20;
        plan_en[0][2] = 1'b1; plan_val[0][2] = 32'h40;
        run_op(32'd0, 32'd1, 3'b010, 0, 1'b0);

        // exhausted retries: replicas return 1, 2, 4 every time
        for (int j = 0; j <= MAXR; j++) begin
            plan_en[j][0] = 1'b1; plan_val[j][0] = 32'd1;
            plan_en[j][1] = 1'b1; plan_val[j][1] = 32'd2;
            plan_en[j][2] = 1'b1; plan_val[j][2] = 32'd4;
        end
        run_op(32'd3, 32'd9, 3'b111, 0, 1'b0);

        // backpressure for 10 cycles on a faulting op
        plan_en[0][2] = 1'b1; plan_val[0][2] = 32'h0;
        run_op(32'h1234, 32'h1, 3'b110, 10, 1'b0);

        // saturation, then clear coinciding with a faulting vote
        for (int n = 0; n < 5; n++) begin
            plan_en[0][n % 3] = 1'b1; plan_val[0][n % 3] = 32'hFFFF_0000 + 32'(n);
            run_op(32'(n), 32'd100, 3'b001, 0, 1'b0);
        end
        plan_en[0][0] = 1'b1; plan_val[0][0] = 32'h5A5A5A5A;
        run_op(32'd8, 32'd8, 3'b000, 0, 1'b1);

        // reset asserted during VOTE
        plan_en[0][1] = 1'b1; plan_val[0][1] = 32'h77;
        run_op(32'd1, 32'd1, 3'b010, 0, 1'b0);
        issue(32'hAAAA_0000, 32'h5555, 3'b001);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midop_rst_ctrl", {62'd0, rsp_valid, req_ready}, 64'd0);
        check("midop_rst_data", {29'd0, alu_cont, alu_a}, 64'd0);
        check("midop_rst_rsp", {30'd0, rsp_zero, rsp_fault, rsp_result}, 64'd0);
        check("midop_rst_stats", {59'd0, fault_mask, fault_count}, 64'd0);
        m_mask = '0; m_cnt = 0;
        clear_plan();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("midop_no_rsp", {62'd0, rsp_valid, req_ready}, {62'd0, 1'b0, 1'b1});
        run_op(32'd40, 32'd2, 3'b010, 0, 1'b0);

        // randomized operations
        for (int n = 0; n < 60; n++) begin
            ra = $urandom; rb = $urandom; rc = 3'($urandom_range(0, 7));
            g  = alu_ref(ra, rb, rc);
            for (int j = 0; j <= MAXR; j++) begin
                scen = (j == MAXR && $urandom_range(0, 1) == 0) ? 9 : int'($urandom_range(0, 9));
                if (j > 0 && scen < 7 && $urandom_range(0, 3) != 0) scen = 7;
                rep  = int'($urandom_range(0, 2));
                if (scen >= 4 && scen <= 6) begin
                    plan_en[j][rep]  = 1'b1;
                    plan_val[j][rep] = (scen == 6) ? $urandom : g ^ (32'd1 << $urandom_range(0, 31));
                end else if (scen >= 7) begin
                    plan_en[j][0] = 1'b1; plan_val[j][0] = g ^ 32'h1;
                    plan_en[j][1] = 1'b1; plan_val[j][1] = g ^ 32'h2;
                    plan_en[j][2] = 1'b1; plan_val[j][2] = (scen == 9) ? ~g : g;
                end
            end
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
